// File: rtl/axis_frame_trunc_if.sv
// AXI-stream bundle used on both sides of the frame truncation stage.
// The master drives the payload and tvalid; the slave drives tready.
interface axis_frame_trunc_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned KEEP_W = (DATA_W + 7) / 8,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned DST_W  = 8,
  parameter int unsigned USR_W  = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic [ID_W-1:0]   tid;
  logic [DST_W-1:0]  tdest;
  logic [USR_W-1:0]  tuser;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tvalid, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_frame_trunc.sv
// Enforces a run-time maximum frame length on an AXI stream: oversized frames
// are cut at the limit beat (tlast forced, optionally marked) and the tail dropped.
module axis_frame_trunc #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned KEEP_W     = (DATA_W + 7) / 8,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned DST_W      = 8,
  parameter int unsigned USR_W      = 1,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned TRUNC_MARK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_frame_trunc_if.slave     s_axis,
  axis_frame_trunc_if.master    m_axis,
  input  logic [LEN_W-1:0]      max_len,
  output logic                  stat_trunc,
  output logic                  stat_frame,
  output logic [15:0]           stat_drop_cnt
);

  typedef enum logic {ST_PASS = 1'b0, ST_DROP = 1'b1} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DST_W-1:0]  dest;
    logic [USR_W-1:0]  user;
  } pay_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [LEN_W-1:0] r_len_lim;
  pay_t             r_out_pay;
  logic             r_out_valid;
  pay_t             r_skid_pay;
  logic             r_skid_valid;
  logic             r_stat_trunc;
  logic             r_stat_frame;
  logic [15:0]      r_drop_cnt;

  logic             w_s_ready;
  logic             w_fwd;
  logic             w_drop;
  logic             w_trunc;
  logic             w_limit_hit;
  logic             w_mark;
  logic             w_out_ready;
  logic [LEN_W-1:0] w_len_lim;
  logic [LEN_W-1:0] w_cnt_sat;
  pay_t             w_in_pay;

  // The first beat of a frame is judged against the live max_len, later beats against the latched copy.
  assign w_len_lim   = (r_beat_cnt == '0) ? max_len : r_len_lim;
  assign w_limit_hit = (w_len_lim != '0) &&
                       (((LEN_W+1)'(r_beat_cnt) + (LEN_W+1)'(1)) == (LEN_W+1)'(w_len_lim));
  assign w_cnt_sat   = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + LEN_W'(1);
  assign w_mark      = (TRUNC_MARK != 0) && w_trunc;
  assign w_out_ready = ~r_out_valid | m_axis.tready;

  assign w_in_pay.data = s_axis.tdata;
  assign w_in_pay.keep = s_axis.tkeep;
  assign w_in_pay.last = s_axis.tlast | w_trunc;
  assign w_in_pay.id   = s_axis.tid;
  assign w_in_pay.dest = s_axis.tdest;
  assign w_in_pay.user = s_axis.tuser | USR_W'(w_mark);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_PASS;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PASS: if (w_trunc) w_state_nxt = ST_DROP;
      ST_DROP: if (w_drop && s_axis.tlast) w_state_nxt = ST_PASS;
      default: w_state_nxt = ST_PASS;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_fwd     = 1'b0;
    w_drop    = 1'b0;
    w_trunc   = 1'b0;
    case (r_state)
      ST_PASS: begin
        w_s_ready = r_live & ~r_skid_valid;
        w_fwd     = s_axis.tvalid & w_s_ready;
        w_trunc   = w_fwd & w_limit_hit & ~s_axis.tlast;
      end
      ST_DROP: begin
        w_s_ready = r_live;
        w_drop    = s_axis.tvalid & w_s_ready;
      end
      default: ;
    endcase
  end

  // Frame bookkeeping and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live       <= 1'b0;
      r_beat_cnt   <= '0;
      r_len_lim    <= '0;
      r_stat_trunc <= 1'b0;
      r_stat_frame <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_live       <= 1'b1;
      r_stat_trunc <= w_trunc;
      r_stat_frame <= (w_fwd | w_drop) & s_axis.tlast;
      if (w_fwd && r_beat_cnt == '0) r_len_lim <= max_len;
      if (w_fwd)                      r_beat_cnt <= s_axis.tlast ? '0 : w_cnt_sat;
      else if (w_drop && s_axis.tlast) r_beat_cnt <= '0;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Output register backed by one skid entry; the skid always drains first to keep order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_pay    <= '0;
      r_out_valid  <= 1'b0;
      r_skid_pay   <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_out_ready) begin
      if (r_skid_valid) begin
        r_out_pay    <= r_skid_pay;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_fwd) begin
        r_out_pay    <= w_in_pay;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_fwd) begin
      r_skid_pay   <= w_in_pay;
      r_skid_valid <= 1'b1;
    end
  end

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = r_out_valid;
  assign m_axis.tdata  = r_out_pay.data;
  assign m_axis.tkeep  = r_out_pay.keep;
  assign m_axis.tlast  = r_out_pay.last;
  assign m_axis.tid    = r_out_pay.id;
  assign m_axis.tdest  = r_out_pay.dest;
  assign m_axis.tuser  = r_out_pay.user;
  assign stat_trunc    = r_stat_trunc;
  assign stat_frame    = r_stat_frame;
  assign stat_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_axis_frame_trunc.sv
// Scoreboard bench for axis_frame_trunc: expected beats are queued as stimulus
// is driven and compared against beats captured from the output handshake.
module tb_axis_frame_trunc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] max_len;
  logic        stat_trunc;
  logic        stat_frame;
  logic [15:0] stat_drop_cnt;

  always #5 clk = ~clk;

  axis_frame_trunc_if s_axis ();
  axis_frame_trunc_if m_axis ();

  axis_frame_trunc dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .max_len       (max_len),
    .stat_trunc    (stat_trunc),
    .stat_frame    (stat_frame),
    .stat_drop_cnt (stat_drop_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic [7:0] id;
    logic [7:0] dest;
    logic       user;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t cur;
  beat_t held;
  bit    stalled = 1'b0;
  int    stall_viol = 0;
  int    n_trunc = 0;
  int    n_frame = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    rdy_mode = 0;

  assign cur = {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser};

  function automatic beat_t mk(input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b.data = d; b.keep = 1'b1; b.last = l; b.id = 8'(d + 8'd1); b.dest = ~d; b.user = u;
    return b;
  endfunction

  // Output monitor: captures transfers, stall stability and stat pulses.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && (m_axis.tvalid !== 1'b1 || cur !== held)) stall_viol++;
      if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) obs_q.push_back(cur);
      stalled = (m_axis.tvalid === 1'b1) && (m_axis.tready !== 1'b1);
      held = cur;
      if (stat_trunc === 1'b1) n_trunc++;
      if (stat_frame === 1'b1) n_frame++;
    end
  end

  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis.tready = 1'b0;
        1:       m_axis.tready = 1'b1;
        default: m_axis.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic idle(input int n);
    s_axis.tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, output int waits);
    bit acc = 1'b0;
    s_axis.tdata = d; s_axis.tkeep = 1'b1; s_axis.tlast = l;
    s_axis.tid = 8'(d + 8'd1); s_axis.tdest = ~d; s_axis.tuser = 1'b0;
    s_axis.tvalid = 1'b1;
    waits = 0;
    while (!acc && waits < 1000) begin
      @(negedge clk);
      if (s_axis.tready === 1'b1) acc = 1'b1;
      else waits++;
    end
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout: beat %02h never accepted, required acceptance", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, output int waits);
    int w;
    waits = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(8'(base + 8'(i)), i == n - 1, w);
      waits += w;
    end
  endtask

  task automatic wait_out(output bit timeout);
    int c = 0;
    idle(3);
    while (obs_q.size() < exp_q.size() && c < 2000) begin
      @(negedge clk);
      c++;
    end
    idle(3);
    timeout = (obs_q.size() != exp_q.size());
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_axis.tvalid); end
    n_tests++; if (s_axis.tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", s_axis.tready); end
    n_tests++; if (m_axis.tdata !== 8'h00) begin n_fail++; $display("FAIL rst_tdata: got %h want 00", m_axis.tdata); end
    n_tests++; if ({stat_trunc, stat_frame, stat_drop_cnt} !== 18'd0) begin
      n_fail++; $display("FAIL rst_stats: got %b %b %0d want 0 0 0", stat_trunc, stat_frame, stat_drop_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (s_axis.tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready: got %b want 1", s_axis.tready); end
  endtask

  task automatic test_pass();
    int w; bit to; int f0 = n_frame; int t0 = n_trunc; beat_t e, o;
    max_len = 16'd4; rdy_mode = 1; idle(2);
    exp_q.push_back(mk(8'h11, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h22, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h33, 1'b1, 1'b0));
    send_beat(8'h11, 1'b0, w);
    s_axis.tvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 8'h11) begin
      n_fail++; $display("FAIL pass_latency: got v=%b d=%h want v=1 d=11", m_axis.tvalid, m_axis.tdata); end
    @(posedge clk); #1;
    send_beat(8'h22, 1'b0, w);
    send_beat(8'h33, 1'b1, w);
    wait_out(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL pass_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL pass_beat: got %h want %h", o, e); end
    end
    n_tests++; if (n_frame - f0 != 1) begin n_fail++; $display("FAIL pass_stat_frame: got %0d want 1", n_frame - f0); end
    n_tests++; if (n_trunc != t0) begin n_fail++; $display("FAIL pass_stat_trunc: got %0d want 0", n_trunc - t0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_trunc();
    int w; bit to; int t0 = n_trunc; int f0 = n_frame; logic [15:0] d0 = stat_drop_cnt; beat_t e, o;
    max_len = 16'd4; rdy_mode = 1; idle(2);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(8'(i), i == 3, i == 3));
    for (int i = 0; i < 4; i++) send_beat(8'(i), 1'b0, w);
    rdy_mode = 0;
    for (int i = 4; i < 10; i++) begin
      send_beat(8'(i), i == 9, w);
      n_tests++; if (w != 0) begin n_fail++; $display("FAIL trunc_drop_ready: beat %0d waited %0d want 0", i, w); end
    end
    rdy_mode = 1;
    wait_out(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL trunc_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL trunc_beat: got %h want %h", o, e); end
    end
    n_tests++; if (n_trunc - t0 != 1) begin n_fail++; $display("FAIL trunc_stat_trunc: got %0d want 1", n_trunc - t0); end
    n_tests++; if (n_frame - f0 != 1) begin n_fail++; $display("FAIL trunc_stat_frame: got %0d want 1", n_frame - f0); end
    n_tests++; if (stat_drop_cnt !== 16'(d0 + 16'd6)) begin
      n_fail++; $display("FAIL trunc_drop_cnt: got %0d want %0d", stat_drop_cnt, d0 + 16'd6); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_exact();
    int w; bit to; int t0 = n_trunc; logic [15:0] d0 = stat_drop_cnt; beat_t e, o;
    max_len = 16'd4; rdy_mode = 1; idle(2);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(8'(8'h40 + 8'(i)), i == 3, 1'b0));
    send_frame(8'h40, 4, w);
    wait_out(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL exact_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL exact_beat: got %h want %h", o, e); end
    end
    n_tests++; if (n_trunc != t0) begin n_fail++; $display("FAIL exact_stat_trunc: got %0d want 0", n_trunc - t0); end
    n_tests++; if (stat_drop_cnt !== d0) begin n_fail++; $display("FAIL exact_drop_cnt: got %0d want %0d", stat_drop_cnt, d0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int w; int wsum; bit to; int v0 = stall_viol; beat_t e, o;
    max_len = 16'd0; rdy_mode = 2; idle(2);
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(8'(f * 16 + i), i == 4, 1'b0));
    for (int f = 0; f < 4; f++) send_frame(8'(f * 16), 5, w);
    rdy_mode = 1;
    wait_out(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL b2b_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_beat: got %h want %h", o, e); end
    end
    n_tests++; if (stall_viol != v0) begin n_fail++; $display("FAIL b2b_stall_stable: got %0d violations want 0", stall_viol - v0); end
    exp_q.delete(); obs_q.delete();
    wsum = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(8'(8'hA0 + 8'(f * 16 + i)), i == 4, 1'b0));
    for (int f = 0; f < 2; f++) begin
      send_frame(8'(8'hA0 + 8'(f * 16)), 5, w);
      wsum += w;
    end
    n_tests++; if (wsum != 0) begin n_fail++; $display("FAIL b2b_full_rate: got %0d stall cycles want 0", wsum); end
    wait_out(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL b2b_rate_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_rate_beat: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_len_change();
    int w; bit to; int t0 = n_trunc; logic [15:0] d0 = stat_drop_cnt; beat_t e, o;
    max_len = 16'd4; rdy_mode = 1; idle(2);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(8'(8'h60 + 8'(i)), i == 3, i == 3));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(8'(8'h70 + 8'(i)), i == 1, i == 1));
    exp_q.push_back(mk(8'hB0, 1'b1, 1'b1));
    for (int i = 0; i < 6; i++) begin
      if (i == 1) max_len = 16'd2;
      send_beat(8'(8'h60 + 8'(i)), i == 5, w);
    end
    send_frame(8'h70, 6, w);
    max_len = 16'd1;
    send_frame(8'hB0, 3, w);
    wait_out(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL len_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL len_beat: got %h want %h", o, e); end
    end
    n_tests++; if (n_trunc - t0 != 3) begin n_fail++; $display("FAIL len_stat_trunc: got %0d want 3", n_trunc - t0); end
    n_tests++; if (stat_drop_cnt !== 16'(d0 + 16'd8)) begin
      n_fail++; $display("FAIL len_drop_cnt: got %0d want %0d", stat_drop_cnt, d0 + 16'd8); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_drop();
    int w; bit to; beat_t e, o;
    max_len = 16'd2; rdy_mode = 0; idle(3);
    send_beat(8'h80, 1'b0, w);
    send_beat(8'h81, 1'b0, w);
    send_beat(8'h82, 1'b0, w);
    n_tests++; if (w != 0) begin n_fail++; $display("FAIL rdrop_ready: waited %0d want 0", w); end
    s_axis.tvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (m_axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL rdrop_held: got %b want 1", m_axis.tvalid); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL rdrop_tvalid: got %b want 0", m_axis.tvalid); end
    n_tests++; if (s_axis.tready !== 1'b0) begin n_fail++; $display("FAIL rdrop_tready: got %b want 0", s_axis.tready); end
    exp_q.delete(); obs_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; rdy_mode = 1;
    @(posedge clk); #1;
    n_tests++; if (s_axis.tready !== 1'b1) begin n_fail++; $display("FAIL rdrop_release_tready: got %b want 1", s_axis.tready); end
    n_tests++; if (stat_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rdrop_drop_cnt: got %0d want 0", stat_drop_cnt); end
    exp_q.push_back(mk(8'h90, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h91, 1'b1, 1'b0));
    send_frame(8'h90, 2, w);
    wait_out(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rdrop_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL rdrop_beat: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0;
    s_axis.tid = '0; s_axis.tdest = '0; s_axis.tuser = '0;
    max_len = 16'd0;
    test_reset();
    test_pass();
    test_trunc();
    test_exact();
    test_back_to_back();
    test_len_change();
    test_reset_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
